// File: rtl/ch0re_mem_arbiter_if.sv
// rtl/ch0re_mem_arbiter_if.sv - fetch/data requester and memory macro bus for the ch0re memory arbiter
interface ch0re_mem_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 12
);
    logic                      if_req;
    logic [63:0]               if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [31:0]               if_rdata;

    logic                      d_req;
    logic                      d_we;
    logic [7:0]                d_be;
    logic [63:0]               d_addr;
    logic [63:0]               d_wdata;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [63:0]               d_rdata;

    logic                      mem_en;
    logic [7:0]                mem_wen;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [63:0]               mem_wdata;
    logic [63:0]               mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    // Requesters plus memory macro side
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ch0re_mem_arbiter.sv
// rtl/ch0re_mem_arbiter.sv - data-priority fetch/data arbiter with starvation guard over one 64-bit memory
module ch0re_mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ch0re_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       owner_if;
    logic       owner_d;
    logic       sel_hi;
    logic       gnt_if;
    logic       gnt_d;

    // Grant decision: data wins conflicts unless fetch has been starved LIMIT cycles; nothing granted in reset
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (rst_n) begin
            if (bus.d_req && !(bus.if_req && starve_cnt == LIMIT)) begin
                gnt_d = 1'b1;
            end else if (bus.if_req) begin
                gnt_if = 1'b1;
            end
        end
    end

    // Memory macro drive for the granted requester; idle bus is all zeros
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wen   = 8'h00;
        bus.mem_addr  = '0;
        bus.mem_wdata = 64'h0;
        if (gnt_d) begin
            bus.mem_en    = 1'b1;
            bus.mem_wen   = bus.d_we ? bus.d_be : 8'h00;
            bus.mem_addr  = bus.d_addr[3 +: MEM_ADDR_WIDTH];
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt_if) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr[3 +: MEM_ADDR_WIDTH];
        end
    end

    // Response ownership and fetch starvation tracking; reset drops any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            owner_if   <= 1'b0;
            owner_d    <= 1'b0;
            sel_hi     <= 1'b0;
        end else begin
            owner_if <= gnt_if;
            owner_d  <= gnt_d;
            if (gnt_if || gnt_d) begin
                sel_hi <= bus.if_addr[2];
            end
            if (gnt_if) begin
                starve_cnt <= 4'd0;
            end else if (bus.if_req && starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Route the registered memory read back to whichever port owned last cycle's grant
    always_comb begin
        bus.if_gnt    = gnt_if;
        bus.d_gnt     = gnt_d;
        bus.if_rvalid = owner_if;
        bus.if_rdata  = sel_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        bus.d_rvalid  = owner_d;
        bus.d_rdata   = bus.mem_rdata;
    end

    // Byte offset and out-of-range address bits are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[63:MEM_ADDR_WIDTH+3],
                                bus.d_addr[2:0], bus.d_addr[63:MEM_ADDR_WIDTH+3]};

endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// tb/tb_ch0re_mem_arbiter.sv - scoreboard bench for the ch0re memory arbiter
module tb_ch0re_mem_arbiter;

    localparam int AW  = 12;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ch0re_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW)) bus ();

    ch0re_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // kind: 0 none, 1 fetch, 2 load, 3 store
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] mem    [4096];
    logic [63:0] shadow [4096];

    function automatic logic [63:0] init_word(int i);
        return {16'hAAAA, 4'h0, 12'(i), 16'h5555, 4'h0, 12'(i)};
    endfunction

    function automatic void shadow_write(int idx, logic [7:0] be, logic [63:0] wd);
        for (int b = 0; b < 8; b++)
            if (be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Synchronous write-first memory macro
    always @(posedge clk) begin
        logic [63:0] w;
        if (bus.mem_en) begin
            w = mem[bus.mem_addr];
            for (int b = 0; b < 8; b++)
                if (bus.mem_wen[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem[bus.mem_addr] <= w;
            bus.mem_rdata     <= w;
        end
    end

    task automatic drive(input logic ir, input logic [63:0] ia, input logic dr, input logic we,
                         input logic [7:0] be, input logic [63:0] da, input logic [63:0] dw);
        bus.if_req = ir; bus.if_addr = ia;
        bus.d_req = dr; bus.d_we = we; bus.d_be = be; bus.d_addr = da; bus.d_wdata = dw;
    endtask

    task automatic test_reset();
        drive(1'b1, 64'h100, 1'b1, 1'b1, 8'hFF, 64'h8, 64'h1);
        @(negedge clk);
        n_cmp++; if (bus.if_gnt !== 1'b0) begin n_err++; $display("FAIL reset_if_gnt got %b exp 0", bus.if_gnt); end
        n_cmp++; if (bus.d_gnt !== 1'b0) begin n_err++; $display("FAIL reset_d_gnt got %b exp 0", bus.d_gnt); end
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.mem_wen !== 8'h00) begin n_err++; $display("FAIL reset_mem got en=%b wen=%h exp 0/00", bus.mem_en, bus.mem_wen); end
        n_cmp++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b%b exp 00", bus.if_rvalid, bus.d_rvalid); end
        drive(1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("FAIL reset_starve got %0d exp 0", dut.starve_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_only();
        logic [63:0] addrs [4];
        exp_t e, o;
        addrs[0] = 64'h150; addrs[1] = 64'h154; addrs[2] = 64'h158; addrs[3] = 64'h0;
        sbq.delete();
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, addrs[c], 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
            @(negedge clk);
            if (sbq.size() > 0) begin
                o = sbq.pop_front();
                n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== o.data[31:0]) begin n_err++; $display("FAIL fetch_rdata c=%0d got v=%b %h exp 1 %h", c, bus.if_rvalid, bus.if_rdata, o.data[31:0]); end
            end
            n_cmp++; if (bus.if_gnt !== (c < 3)) begin n_err++; $display("FAIL fetch_gnt c=%0d got %b exp %b", c, bus.if_gnt, c < 3); end
            if (c < 3) begin
                n_cmp++; if (bus.mem_addr !== addrs[c][14:3] || bus.mem_wen !== 8'h00) begin n_err++; $display("FAIL fetch_mem c=%0d got %h/%h exp %h/00", c, bus.mem_addr, bus.mem_wen, addrs[c][14:3]); end
                e.kind = 2'd1;
                e.data = addrs[c][2] ? {32'h0, shadow[addrs[c][14:3]][63:32]} : {32'h0, shadow[addrs[c][14:3]][31:0]};
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_conflict();
        exp_t e, o;
        logic ig;
        sbq.delete();
        for (int c = 0; c < 11; c++) begin
            drive(c < 10, 64'h204, c < 10, 1'b0, 8'h00, 64'h10, 64'h0);
            @(negedge clk);
            if (sbq.size() > 0) begin
                o = sbq.pop_front();
                n_cmp++;
                if (bus.if_rvalid !== (o.kind == 2'd1) || bus.d_rvalid !== (o.kind == 2'd2) ||
                    (o.kind == 2'd1 && bus.if_rdata !== o.data[31:0]) || (o.kind == 2'd2 && bus.d_rdata !== o.data)) begin
                    n_err++; $display("FAIL conflict_resp c=%0d got %b%b exp kind %0d", c, bus.if_rvalid, bus.d_rvalid, o.kind);
                end
            end
            if (c < 10) begin
                ig = (c == 4 || c == 9);
                n_cmp++; if (bus.if_gnt !== ig || bus.d_gnt !== !ig) begin n_err++; $display("FAIL conflict_gnt c=%0d got if=%b d=%b exp if=%b", c, bus.if_gnt, bus.d_gnt, ig); end
                e.kind = ig ? 2'd1 : 2'd2;
                e.data = ig ? {32'h0, shadow[12'h40][63:32]} : shadow[2];
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_load();
        drive(1'b0, 64'h0, 1'b1, 1'b1, 8'h0F, 64'h40, 64'h1122334455667788);
        @(negedge clk);
        n_cmp++; if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_wen !== 8'h0F || bus.mem_addr !== 12'h8 || bus.mem_wdata !== 64'h1122334455667788) begin
            n_err++; $display("FAIL store_mem got gnt=%b en=%b wen=%h idx=%h wd=%h exp 1 1 0f 008 1122334455667788", bus.d_gnt, bus.mem_en, bus.mem_wen, bus.mem_addr, bus.mem_wdata); end
        shadow_write(8, 8'h0F, 64'h1122334455667788);
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b1, 1'b0, 8'hFF, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL store_ack got %b exp 1", bus.d_rvalid); end
        n_cmp++; if (bus.d_gnt !== 1'b1 || bus.mem_wen !== 8'h00) begin n_err++; $display("FAIL load_mem got gnt=%b wen=%h exp 1 00", bus.d_gnt, bus.mem_wen); end
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b1, 1'b1, 8'h00, 64'h48, 64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata[31:0] !== 32'h55667788) begin n_err++; $display("FAIL load_lo got %b %h exp 1 55667788", bus.d_rvalid, bus.d_rdata[31:0]); end
        n_cmp++; if (bus.d_rdata !== shadow[8]) begin n_err++; $display("FAIL load_full got %h exp %h", bus.d_rdata, shadow[8]); end
        n_cmp++; if (bus.d_gnt !== 1'b1 || bus.mem_wen !== 8'h00) begin n_err++; $display("FAIL be0_gnt got %b wen=%h exp 1 00", bus.d_gnt, bus.mem_wen); end
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h48, 64'h0);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL be0_ack got %b exp 1", bus.d_rvalid); end
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== shadow[9]) begin n_err++; $display("FAIL be0_unchanged got %b %h exp 1 %h", bus.d_rvalid, bus.d_rdata, shadow[9]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h100, 1'b1, 1'b0, 8'h00, 64'h18, 64'h0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.d_gnt !== 1'b1 || dut.starve_cnt !== 4'd2) begin n_err++; $display("FAIL mid_pre got gnt=%b starve=%0d exp 1 2", bus.d_gnt, dut.starve_cnt); end
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_inrst_rvalid got %b%b exp 00", bus.if_rvalid, bus.d_rvalid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h20, 64'h0);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_dropped got %b exp 0", bus.d_rvalid); end
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("FAIL mid_starve got %0d exp 0", dut.starve_cnt); end
        n_cmp++; if (bus.d_gnt !== 1'b1) begin n_err++; $display("FAIL mid_first_gnt got %b exp 1", bus.d_gnt); end
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        @(negedge clk);
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== shadow[4]) begin n_err++; $display("FAIL mid_first_resp got %b %h exp 1 %h", bus.d_rvalid, bus.d_rdata, shadow[4]); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        ip, dp, dwe, eif, ed;
        logic [63:0] ia, da, dw;
        logic [7:0]  dbe;
        int          ms, denied, idx;
        exp_t        e, o;
        ip = 1'b0; dp = 1'b0; ms = 0; denied = 0;
        ia = 64'h0; da = 64'h0; dw = 64'h0; dwe = 1'b0; dbe = 8'h00;
        sbq.delete();
        for (int c = 0; c <= 10000; c++) begin
            if (c == 10000) begin
                ip = 1'b0; dp = 1'b0;
            end else begin
                if (!ip) begin
                    ip = ($urandom_range(0, 1) == 1);
                    ia = {57'h0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
                end
                if (!dp) begin
                    dp  = ($urandom_range(0, 1) == 1);
                    da  = {57'h0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
                    dwe = ($urandom_range(0, 1) == 1);
                    dbe = 8'($urandom);
                    dw  = {$urandom, $urandom};
                end
            end
            drive(ip, ia, dp, dwe, dbe, da, dw);
            @(negedge clk);
            if (sbq.size() > 0) begin
                o = sbq.pop_front();
                n_cmp++;
                if (bus.if_rvalid !== (o.kind == 2'd1) || bus.d_rvalid !== (o.kind[1] == 1'b1)) begin
                    n_err++; $display("FAIL rand_rvalid c=%0d got if=%b d=%b exp kind %0d", c, bus.if_rvalid, bus.d_rvalid, o.kind);
                end else if ((o.kind == 2'd1 && bus.if_rdata !== o.data[31:0]) || (o.kind == 2'd2 && bus.d_rdata !== o.data)) begin
                    n_err++; $display("FAIL rand_rdata c=%0d kind %0d got %h/%h exp %h", c, o.kind, bus.if_rdata, bus.d_rdata, o.data);
                end
            end
            eif = ip && (!dp || ms == LIM);
            ed  = dp && !eif;
            n_cmp++; if (bus.if_gnt === 1'b1 && bus.d_gnt === 1'b1) begin n_err++; $display("FAIL rand_two_gnt c=%0d got 11 exp at most one", c); end
            n_cmp++; if (bus.if_gnt !== eif || bus.d_gnt !== ed) begin n_err++; $display("FAIL rand_gnt c=%0d got if=%b d=%b exp if=%b d=%b", c, bus.if_gnt, bus.d_gnt, eif, ed); end
            if (ip && bus.if_gnt !== 1'b1) denied++;
            else denied = 0;
            n_cmp++; if (denied > LIM) begin n_err++; $display("FAIL rand_starve c=%0d got %0d denied exp <= %0d", c, denied, LIM); end
            e.kind = 2'd0; e.data = 64'h0;
            if (eif) begin
                idx = int'(ia[14:3]);
                e.kind = 2'd1;
                e.data = ia[2] ? {32'h0, shadow[idx][63:32]} : {32'h0, shadow[idx][31:0]};
                ms = 0; ip = 1'b0;
            end else if (ip) begin
                if (ms < LIM) ms++;
            end
            if (ed) begin
                idx = int'(da[14:3]);
                if (dwe) begin
                    shadow_write(idx, dbe, dw);
                    e.kind = 2'd3;
                end else begin
                    e.kind = 2'd2;
                    e.data = shadow[idx];
                end
                dp = 1'b0;
            end
            sbq.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        bus.mem_rdata = 64'h0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        @(posedge clk); #1;
        test_reset();
        test_fetch_only();
        test_conflict();
        test_store_load();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ch0re_mem_arbiter.md
Name: ch0re_mem_arbiter

Overview:
Two-requester arbiter that shares one synchronous single-port 64-bit memory between the instruction-fetch port and the load/store (data) port of the ch0re 5-stage RV64I pipeline. Each cycle it grants at most one request and routes the registered read response back to its owner one cycle later. Data requests take priority, and a starvation counter guarantees forward progress for instruction fetch. It sits between the IF/MEM stages and the unified memory macro.

Parameters:
MEM_ADDR_WIDTH, 12, width of the memory double-word index (depth = 2**MEM_ADDR_WIDTH x 64 bit)
STARVE_LIMIT, 4, consecutive denied IF cycles after which IF wins the next conflict; legal range 1..15

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held with stable if_addr until if_gnt
if_addr  input  64  fetch byte address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch data valid (one cycle after if_gnt)
if_rdata  output  32  fetched instruction word
d_req  input  1  data request; held with stable payload until d_gnt
d_we  input  1  1 = store, 0 = load
d_be  input  8  store byte-lane enables, already aligned to the double-word
d_addr  input  64  data byte address
d_wdata  input  64  store data, already lane-aligned
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid / store acknowledge (one cycle after d_gnt)
d_rdata  output  64  raw double-word read (sign extension is done by the requester)
mem_en  output  1  memory access this cycle
mem_wen  output  8  memory byte write enables
mem_addr  output  MEM_ADDR_WIDTH  memory double-word index
mem_wdata  output  64  memory write data
mem_rdata  input  64  memory read data, valid one cycle after mem_en

Behaviour:
- Arbitration is combinational and happens in the same cycle as the request. A new grant may be issued every cycle, with full back-to-back throughput.
- Priority:
  - d_req alone -> d_gnt.
  - if_req alone -> if_gnt.
  - Both requesting -> d_gnt, unless starve_cnt == STARVE_LIMIT, in which case if_gnt.
  - Never both grants in the same cycle.
- starve_cnt (4 bits, reset 0):
  - Increments when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on any if_gnt.
  - Holds when if_req=0.
- Memory drive on a data grant:
  - mem_en=1, mem_addr=d_addr[3 +: MEM_ADDR_WIDTH].
  - mem_wen = d_we ? d_be : 8'h00; mem_wdata = d_wdata.
- Memory drive on a fetch grant: mem_en=1, mem_wen=0, mem_addr=if_addr[3 +: MEM_ADDR_WIDTH].
- Memory drive with no grant: mem_en=0, mem_wen=0, mem_addr and mem_wdata = 0.
- Address handling:
  - d_addr[2:0], if_addr[1:0] and address bits above the index are ignored. No exception is raised; that is handled upstream.
  - A store with d_be=0 is still granted and acknowledged.
- Response registers (all reset 0): owner_if, owner_d, sel_hi.
  - On a grant, load owner_if/owner_d (one-hot or both 0) and sel_hi = if_addr[2].
  - If there is no grant, owner bits load 0.
- Response outputs:
  - if_rvalid = owner_if; if_rdata = sel_hi ? mem_rdata[63:32] : mem_rdata[31:0].
  - d_rvalid = owner_d; d_rdata = mem_rdata.
  - Latency is exactly 1 cycle from grant to rvalid.
  - When the matching rvalid is 0, rdata is don't-care. The bench checks it only with rvalid.
- Store ack: d_rvalid pulses for stores as well. d_rdata then carries old or new memory contents per macro behaviour and is not checked.
- Read-after-write to the same index on consecutive cycles returns the written data (the macro is synchronous write-first).
- Reset:
  - While rst_n=0, if_gnt, d_gnt, mem_en, mem_wen, if_rvalid and d_rvalid are all 0.
  - Reset asserted mid-transaction drops the pending response: no rvalid after deassertion, and starve_cnt returns to 0.
  - Requests present on the first cycle after deassertion are arbitrated normally.

Test Plan:
- Fetch only: if_req=1 streaming addresses 0x150, 0x154, 0x158 -> if_gnt every cycle; if_rvalid on the next cycles with words from index 0x2A low, 0x2A high, 0x2B low.
- Conflict and starvation, STARVE_LIMIT=4: d_req and if_req held continuously for 10 cycles.
  - Cycles 0-3 -> d_gnt.
  - Cycle 4 -> if_gnt.
  - Cycles 5-8 -> d_gnt.
  - Cycle 9 -> if_gnt.
- Store then load: d_we=1, d_be=8'h0F, d_addr=0x40, d_wdata=0x1122334455667788, then a load at 0x40 -> mem_wen=0x0F, index 8; the load d_rdata lower 32 bits = 0x55667788.
- Store with d_be=0: request is granted, d_rvalid pulses, memory contents are unchanged.
- Reset mid-operation: load granted, rst_n asserted on the next edge -> d_rvalid stays 0 and starve_cnt reads 0 after release.
- Random: if_req and d_req randomised with 50% probability each, 10k cycles. Scoreboard checks:
  - one grant at most per cycle;
  - every grant is followed by exactly one matching rvalid;
  - IF is never denied more than STARVE_LIMIT consecutive cycles.
